// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter/sequencer sharing one FPU adder core
// between two requesters. Operands are held on the FPU inputs for
// FPU_LATENCY cycles, then the FPU result/status is returned to the owner
// through a valid/ready response handshake.
// Optional feature: define FPU_ARB_ZERO_BYPASS_EN to skip the FPU when an
// accepted operand is zero (bits[30:0] == 0).
module fpu_arbiter #(
  parameter int FPU_LATENCY = 12,
  parameter int CNT_W       = 16
) (
  input  logic             clock_100Khz,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_a_0,
  input  logic [31:0]      req_b_0,
  input  logic [31:0]      req_a_1,
  input  logic [31:0]      req_b_1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [1:0]       rsp_status,
  output logic [31:0]      fpu_op_a,
  output logic [31:0]      fpu_op_b,
  input  logic [31:0]      fpu_data_in,
  input  logic [1:0]       fpu_status_in,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt_0,
  output logic [CNT_W-1:0] done_cnt_1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0]       LAT_M1       = 8'(FPU_LATENCY - 1);
  localparam logic [1:0]       STATUS_EXACT = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_grant;
  logic             r_owner;
  logic [7:0]       r_cnt;
  logic [31:0]      r_fpu_op_a;
  logic [31:0]      r_fpu_op_b;
  logic [31:0]      r_rsp_data;
  logic [1:0]       r_rsp_status;
  logic [1:0]       r_rsp_valid;
  logic [CNT_W-1:0] r_done_cnt_0;
  logic [CNT_W-1:0] r_done_cnt_1;

  logic             w_any_valid;
  logic             w_winner;
  logic [1:0]       w_winner_onehot;
  logic [1:0]       w_owner_onehot;
  logic [31:0]      w_sel_a;
  logic [31:0]      w_sel_b;
  logic             w_accept;
  logic             w_cnt_zero;
  logic             w_rsp_fire;
  logic             w_bypass;
  logic [31:0]      w_bypass_data;

  // Round-robin winner: a lone requester wins, a tie goes to the one not granted last
  always_comb begin
    w_any_valid = |req_valid;
    if (req_valid == 2'b11) begin
      w_winner = ~r_last_grant;
    end else if (req_valid[1]) begin
      w_winner = 1'b1;
    end else begin
      w_winner = 1'b0;
    end
    w_winner_onehot = w_winner ? 2'b10 : 2'b01;
    if (w_winner) begin
      w_sel_a = req_a_1;
      w_sel_b = req_b_1;
    end else begin
      w_sel_a = req_a_0;
      w_sel_b = req_b_0;
    end
  end

`ifdef FPU_ARB_ZERO_BYPASS_EN
  logic w_a_zero;
  logic w_b_zero;

  // Zero-operand shortcut: the sum is the other operand, -0 only for (-0)+(-0)
  always_comb begin
    w_a_zero = (w_sel_a[30:0] == 31'd0);
    w_b_zero = (w_sel_b[30:0] == 31'd0);
    w_bypass = w_a_zero | w_b_zero;
    if (w_a_zero && w_b_zero) begin
      w_bypass_data = {w_sel_a[31] & w_sel_b[31], 31'd0};
    end else if (w_a_zero) begin
      w_bypass_data = w_sel_b;
    end else if (w_b_zero) begin
      w_bypass_data = w_sel_a;
    end else begin
      w_bypass_data = 32'd0;
    end
  end
`else
  // Every request goes through the FPU; no shortcut path exists
  always_comb begin
    w_bypass      = 1'b0;
    w_bypass_data = 32'd0;
  end
`endif

  assign w_owner_onehot = r_owner ? 2'b10 : 2'b01;
  assign w_accept       = |(req_valid & req_ready);
  assign w_cnt_zero     = (r_cnt == 8'd0);
  assign w_rsp_fire     = (r_state == ST_RESP) && rsp_ready[r_owner];

  // State register; reset drops any in-flight operation
  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decision
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = w_bypass ? ST_RESP : ST_WAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (w_cnt_zero) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (w_rsp_fire) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Per-state outputs: grant only in IDLE, busy everywhere else
  always_comb begin
    req_ready = 2'b00;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_any_valid) begin
          req_ready = w_winner_onehot;
        end else begin
          req_ready = 2'b00;
        end
      end
      ST_WAIT, ST_RESP: begin
        busy      = 1'b1;
        req_ready = 2'b00;
      end
      default: begin
        busy      = 1'b1;
        req_ready = 2'b00;
      end
    endcase
  end

  // Operand latch, latency countdown, result capture and completion counters
  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= 8'd0;
      r_fpu_op_a   <= 32'd0;
      r_fpu_op_b   <= 32'd0;
      r_rsp_data   <= 32'd0;
      r_rsp_status <= STATUS_EXACT;
      r_rsp_valid  <= 2'b00;
      r_done_cnt_0 <= {CNT_W{1'b0}};
      r_done_cnt_1 <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_fpu_op_a   <= w_sel_a;
            r_fpu_op_b   <= w_sel_b;
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
            r_cnt        <= LAT_M1;
            if (w_bypass) begin
              r_rsp_data   <= w_bypass_data;
              r_rsp_status <= STATUS_EXACT;
              r_rsp_valid  <= w_winner_onehot;
            end
          end
        end
        ST_WAIT: begin
          if (w_cnt_zero) begin
            r_rsp_data   <= fpu_data_in;
            r_rsp_status <= fpu_status_in;
            r_rsp_valid  <= w_owner_onehot;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 2'b00;
            if (r_owner) begin
              r_done_cnt_1 <= r_done_cnt_1 + CNT_ONE;
            end else begin
              r_done_cnt_0 <= r_done_cnt_0 + CNT_ONE;
            end
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
        end
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_rsp_status;
  assign fpu_op_a   = r_fpu_op_a;
  assign fpu_op_b   = r_fpu_op_b;
  assign done_cnt_0 = r_done_cnt_0;
  assign done_cnt_1 = r_done_cnt_1;

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Round-robin arbiter and sequencer that shares one FPU adder core between two requesters. Each requester presents an operand pair through a valid/ready handshake. The block drives the FPU operand inputs and holds them stable for a fixed number of cycles. It then captures the FPU result and status and returns them to the owning requester through a valid/ready response handshake. It sits between the requesting units and the FPU core, and is the only block allowed to drive the FPU operand inputs.

## Interface
Parameters:
- FPU_LATENCY, default 12: cycles operands are held before the FPU result is sampled. Legal range 2..255. Must be ≥ the FPU worst-case DECODE→WRITEBACK round trip.
- CNT_W, default 16: width of the per-requester completed-operation counters.

Ports:
- clock_100Khz, in, 1: system clock. All logic is on its rising edge.
- reset, in, 1: asynchronous, active-low.
- req_valid, in, 2: bit i is high when requester i has an operand pair.
- req_ready, out, 2: bit i is high when requester i is accepted this cycle. At most one bit is high.
- req_a_0 / req_b_0, in, 32 each: requester 0 operands.
- req_a_1 / req_b_1, in, 32 each: requester 1 operands.
- rsp_valid, out, 2: bit i is high when a response for requester i is pending.
- rsp_ready, in, 2: requester i accepts its response.
- rsp_data, out, 32: result as {sign, exp[9:0], mant[20:0]}.
- rsp_status, out, 2: 0 = OVERFLOW, 1 = UNDERFLOW, 2 = EXACT, 3 = INEXACT.
- fpu_op_a / fpu_op_b, out, 32 each: FPU operand inputs.
- fpu_data_in, in, 32: FPU data output.
- fpu_status_in, in, 2: FPU status output.
- busy, out, 1: high in every state except IDLE.
- done_cnt_0 / done_cnt_1, out, CNT_W each: number of completed responses per requester. Wraps.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready is combinational. It is set for the winner only, and only when its req_valid is high.
  - Winner rule: if only one requester is valid, it wins. If both are valid, the requester that is not last_grant wins.
  - Acceptance happens when req_valid[i] & req_ready[i] are both high at an edge. On that edge:
    - operands are latched into the fpu_op_a/b registers;
    - owner ← i and last_grant ← i;
    - cnt ← FPU_LATENCY-1;
    - state moves to WAIT.
- WAIT:
  - cnt decrements once per cycle.
  - At the edge where cnt == 0: rsp_data ← fpu_data_in, rsp_status ← fpu_status_in, state moves to RESP.
- RESP:
  - rsp_valid[owner] is held high, with rsp_data and rsp_status stable, until rsp_ready[owner] is high at an edge.
  - On that edge: done_cnt_owner increments and state moves to IDLE.
  - rsp_ready of the non-owner is ignored.
- fpu_op_a/b keep their last latched value until the next acceptance. They never change during WAIT or RESP.
- Only one operation is outstanding at a time. req_ready is low in WAIT and RESP.
- A requester may drop req_valid before it is accepted. No state is affected.
- Reset values:
  - state = IDLE, last_grant = 1 (so requester 0 wins the first tie);
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_status = 2 (EXACT);
  - fpu_op_a = fpu_op_b = 0;
  - done_cnt_0 = done_cnt_1 = 0, busy = 0.
- Reset asserted mid-operation: the transaction is dropped, no response is ever issued, and all registers take their reset values immediately (asynchronous).

## Timing
- Accept edge to rsp_valid high: FPU_LATENCY cycles. With the default this is 12 cycles = 120 µs at 100 kHz.
- Response accepted in the same cycle rsp_valid rises: state is IDLE on the next cycle. A new accept can occur one cycle later.
- Minimum issue interval: FPU_LATENCY + 2 cycles.
- Simultaneous events:
  - a new req_valid arriving while in RESP waits for IDLE;
  - if both requesters are valid in IDLE in consecutive transactions, grants alternate strictly 0, 1, 0, 1.

## Configuration
- FPU_ARB_ZERO_BYPASS_EN defined:
  - An operand is zero when its bits[30:0] == 0.
  - If a zero operand is accepted, the FPU is skipped and state moves IDLE→RESP directly.
  - rsp_data = the other operand. If both operands are zero, rsp_data = {a[31] & b[31], 31'd0}.
  - rsp_status = EXACT, and rsp_valid rises 1 cycle after acceptance.
  - fpu_op_a/b are still updated with the latched operands.
- FPU_ARB_ZERO_BYPASS_EN undefined: every accepted request goes through WAIT with the full FPU_LATENCY.

## Test plan
- Reset check: drive reset low mid-WAIT → rsp_valid = 0, rsp_status = 2, done_cnt_0/1 = 0, busy = 0. No response appears afterwards.
- Single request: requester 0 sends a = 0x3FE00000, b = 0x3FE00000 with an FPU stub returning 0x40000000 / status 2 → rsp_valid[0] rises exactly 12 cycles after acceptance with rsp_data = 0x40000000, rsp_status = 2. done_cnt_0 = 1.
- Contention: both requesters valid continuously for 4 transactions → grant order 0, 1, 0, 1. fpu_op_a stays stable throughout each WAIT.
- Backpressure: hold rsp_ready[1] low for 20 cycles → rsp_valid[1] and rsp_data stay stable. req_ready stays 0. The next grant comes 2 cycles after rsp_ready is raised.
- Bypass with the macro defined: a = 0x00000000, b = 0x40280000 → rsp_data = 0x40280000, status EXACT, 1 cycle after acceptance. Without the macro, the same stimulus takes the 12-cycle path.
- Wrap: preload 0xFFFF completions on requester 1 (CNT_W = 16) → one more completion sets done_cnt_1 = 0x0000.
